// File: rtl/seq_shifter_pkg.sv
// Shared types and helpers for the iterative shift/rotate unit.
package seq_shifter_pkg;

    // Control FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Operation mode, derived from the {rot, lr, ar} request bits
    typedef enum logic [2:0] {
        OpShl  = 3'd0,
        OpShrL = 3'd1,
        OpShrA = 3'd2,
        OpRol  = 3'd3,
        OpRor  = 3'd4
    } op_e;

    // Rotate beats arithmetic; ar only matters for right shifts.
    function automatic op_e decode_op(logic rot, logic lr, logic ar);
        if (rot) begin
            return lr ? OpRol : OpRor;
        end
        if (lr) begin
            return OpShl;
        end
        return ar ? OpShrA : OpShrL;
    endfunction

    // Number of single-bit steps needed. Rotates wrap modulo the width;
    // shifts saturate at the width, which already yields all-fill data.
    function automatic int unsigned calc_n_eff(int unsigned n, int unsigned width, logic rot);
        if (rot) begin
            return n % width;
        end
        return (n < width) ? n : width;
    endfunction

endpackage

// File: rtl/seq_shifter_if.sv
// Request/response bundle of the iterative shifter.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] i;
    logic [CNT_W-1:0] n;
    logic             ar;
    logic             lr;
    logic             rot;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] o;
    logic             busy;

    // Requester / result consumer side
    modport master (
        output in_valid, i, n, ar, lr, rot, out_ready,
        input  in_ready, out_valid, o, busy
    );

    // Shifter side
    modport slave (
        input  in_valid, i, n, ar, lr, rot, out_ready,
        output in_ready, out_valid, o, busy
    );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// One-position shift/rotate step; the datapath applies it once per cycle.
module shift_step
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  op_e              mode,
    output logic [WIDTH-1:0] result
);

    // Move every bit one place and insert the mode-specific fill bit
    always_comb begin
        result = data;
        case (mode)
            OpShl:   result = {data[WIDTH-2:0], 1'b0};
            OpRol:   result = {data[WIDTH-2:0], data[WIDTH-1]};
            OpShrL:  result = {1'b0, data[WIDTH-1:1]};
            OpShrA:  result = {data[WIDTH-1], data[WIDTH-1:1]};
            OpRor:   result = {data[0], data[WIDTH-1:1]};
            default: result = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Iterative shift/rotate unit: one bit position per clock, valid/ready on
// both the request and the result side.
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input logic          clk,
    input logic          nrst,
    seq_shifter_if.slave bus
);

    // One extra bit so a saturated shift count of WIDTH always fits
    localparam int unsigned CW = CNT_W + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    op_e              mode_q, mode_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    n_eff;
    logic [WIDTH-1:0] step_data;
    logic             accept;

    assign n_eff  = CW'(calc_n_eff(32'(bus.n), WIDTH, bus.rot));
    assign accept = bus.in_valid && (state_q == StIdle);

    shift_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .data  (data_q),
        .mode  (mode_q),
        .result(step_data)
    );

    // State, operand and counter registers; reset aborts any operation
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            data_q  <= '0;
            mode_q  <= OpShl;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    data_d  = bus.i;
                    mode_d  = decode_op(bus.rot, bus.lr, bus.ar);
                    cnt_d   = n_eff;
                    state_d = (n_eff != '0) ? StShift : StDone;
                end
            end
            StShift: begin
                data_d = step_data;
                cnt_d  = cnt_q - 1'b1;
                // cnt_q is never 0 here in normal operation; treat it as last step anyway
                if (cnt_q <= CW'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // No accept here even with out_ready high: one bubble cycle
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Handshake/status outputs decode directly from the state register
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.busy      = 1'b0;
        bus.out_valid = 1'b0;
        bus.o         = data_q;
        unique case (state_q)
            StIdle:  bus.in_ready  = 1'b1;
            StShift: bus.busy      = 1'b1;
            StDone:  bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: a driver pushes expected results from a
// plain-arithmetic model, an independent monitor pops and compares them.
module tb_seq_shifter;

    localparam int W  = 8;
    localparam int CW = 4;

    typedef struct {
        logic [W-1:0] o;
        int           lat;
        int           acc;
    } exp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t q[$];
    bit   in_done   = 0;
    logic [W-1:0] held_o;
    int   last_done = -100;
    bit   hold_low  = 0;
    bit   rnd_ready = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    seq_shifter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    seq_shifter #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk (clk),
        .nrst(nrst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: whole-word arithmetic, no per-step iteration
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input int n,
                                           input logic ar, input logic lr, input logic rot);
        int v;
        int k;
        int s;
        v = int'(x);
        if (rot) begin
            k = n % W;
            if (lr) v = (v << k) | (v >> (W - k));
            else    v = (v >> k) | (v << (W - k));
        end else if (lr) begin
            v = (n >= W) ? 0 : (v << n);
        end else if (ar) begin
            s = x[W-1] ? v - (1 << W) : v;
            v = s >>> n;
        end else begin
            v = v >> n;
        end
        return v[W-1:0];
    endfunction

    function automatic int latency(input int n, input logic rot);
        return (rot ? n % W : (n < W ? n : W)) + 1;
    endfunction

    // Issue one request; returns the cycle stamp of the accepting edge
    task automatic send(input logic [W-1:0] x, input int n, input logic ar,
                        input logic lr, input logic rot, output int acc);
        exp_t e;
        int   t;
        @(negedge clk);
        bus.i = x; bus.n = CW'(n); bus.ar = ar; bus.lr = lr; bus.rot = rot;
        bus.in_valid = 1'b1;
        t = 0;
        while (!bus.in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            checks++; failures++;
            $display("FAIL accept_timeout: in_ready stayed %0b, required 1", bus.in_ready);
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        e.o = model(x, n, ar, lr, rot);
        e.lat = latency(n, rot);
        e.acc = cyc + 1;
        acc = e.acc;
        q.push_back(e);
        @(posedge clk);
        #1;
        // Scramble operands after acceptance; they must not matter any more
        bus.in_valid = 1'b0;
        bus.i = W'($urandom); bus.n = CW'($urandom);
        bus.ar = 1'($urandom); bus.lr = 1'($urandom); bus.rot = 1'($urandom);
        @(negedge clk);
        check("busy_after_accept", bus.busy, e.lat > 1);
        check("in_ready_after_accept", bus.in_ready, 0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || in_done) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
    endtask

    // Result consumer
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (hold_low)       bus.out_ready = 1'b0;
            else if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            else                bus.out_ready = 1'b1;
        end
    end

    // Monitor: compares each presented result against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nrst) begin
                in_done = 0;
            end else if (bus.out_valid) begin
                if (!in_done) begin
                    in_done   = 1;
                    held_o    = bus.o;
                    last_done = cyc;
                    if (q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_output: got o=%0h, required no result", bus.o);
                    end else begin
                        e = q.pop_front();
                        check("result", bus.o, e.o);
                        check("latency", cyc - e.acc + 1, e.lat);
                    end
                end else begin
                    check("hold_o", bus.o, held_o);
                end
                check("in_ready_in_done", bus.in_ready, 0);
                check("busy_in_done", bus.busy, 0);
                if (bus.out_ready) in_done = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, d1;
        bus.in_valid = 1'b0; bus.i = '0; bus.n = '0;
        bus.ar = 1'b0; bus.lr = 1'b0; bus.rot = 1'b0;

        // Reset state
        #12;
        check("rst_o", bus.o, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(negedge clk);
        nrst = 1'b1;

        // Directed cases
        send(8'h96, 3, 0, 0, 0, acc);
        send(8'h96, 3, 1, 0, 0, acc);
        send(8'h96, 3, 1, 1, 0, acc);
        send(8'h96, 3, 0, 1, 1, acc);
        send(8'h96, 3, 0, 0, 1, acc);
        send(8'h96, 12, 0, 0, 1, acc);
        send(8'h5A, 0, 0, 0, 0, acc);
        send(8'hA5, 0, 1, 0, 0, acc);
        send(8'hC3, 0, 0, 1, 1, acc);
        send(8'h96, 15, 0, 0, 0, acc);
        send(8'h96, 15, 0, 1, 0, acc);
        send(8'h96, 15, 1, 0, 0, acc);
        send(8'h96, 8, 0, 1, 1, acc);
        drain();

        // Back-to-back: exactly one bubble cycle between completion and next accept
        send(8'h3C, 2, 0, 1, 0, acc);
        send(8'h81, 1, 0, 0, 1, acc2);
        d1 = last_done;
        check("bubble_cycle", acc2 - d1, 2);
        drain();

        // Ignored in_valid pulses while shifting
        send(8'hE7, 7, 1, 0, 0, acc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = ~bus.in_valid;
            bus.i = W'($urandom); bus.n = CW'($urandom);
            check("in_ready_in_shift", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        drain();

        // Hold back the consumer
        hold_low = 1;
        send(8'h96, 3, 0, 1, 1, acc);
        repeat (15) @(negedge clk);
        check("hold_valid", bus.out_valid, 1);
        hold_low = 0;
        drain();

        // Asynchronous reset in the middle of a shift
        send(8'h96, 7, 0, 1, 0, acc);
        @(posedge clk);
        #3 nrst = 1'b0;
        #1;
        check("arst_o", bus.o, 0);
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_in_ready", bus.in_ready, 1);
        q.delete();
        @(negedge clk);
        nrst = 1'b1;
        send(8'h96, 3, 1, 0, 0, acc);
        drain();

        // Randomized traffic with a random consumer
        rnd_ready = 1;
        for (int k = 0; k < 60; k++) begin
            send(W'($urandom), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                 1'($urandom), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();
        rnd_ready = 0;

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL leftover: %0d results pending, required 0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
